// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
//
// Shared definitions for the voting-session sequencer and its neighbours.
//
// Contents:
//   vote_state_e   session FSM state (IDLE, OPEN, SETTLE), 2-bit encoding
//   RES_W_DEFAULT  default width of the voter result, tally and threshold
//   NP_W           width of the normal-voter ballot bus
//   VIP_W          width of the VIP ballot bus
//   CNT_W          width of the vote-window counter (covers WINDOW up to 255)
// ---------------------------------------------------------------------------
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        SETTLE = 2'd2
    } vote_state_e;

    localparam int RES_W_DEFAULT = 8;
    localparam int NP_W          = 32;
    localparam int VIP_W         = 8;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/vote_session_ctrl.sv
// ---------------------------------------------------------------------------
// vote_session_ctrl
//
// Wraps a weighted voter into discrete voting sessions. While idle the voter
// is held in reset and the ballot gates are closed. A session opens a vote
// window of WINDOW cycles in which requester ballots pass straight through to
// the voter, waits one settle cycle so the voter's registered result catches
// up with the last ballot, then latches the tally and compares it against the
// threshold captured at start.
//
// Parameters:
//   WINDOW  number of cycles the vote window stays open (1..255)
//   RES_W   width of voter result, tally and threshold
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         request a new session (only honoured while idle)
//   abort         cancel the running session (ignored while idle)
//   threshold     pass threshold, captured when a start is accepted
//   np_in         normal-voter ballots from requesters
//   vip_in        VIP ballots
//   vvip_in       VVIP ballot
//   voter_reset   reset to the voter, high while idle
//   voter_np      gated normal ballots to the voter
//   voter_vip     gated VIP ballots to the voter
//   voter_vvip    gated VVIP ballot to the voter
//   voter_result  registered result from the voter
//   busy          session in progress
//   done          one-cycle pulse, session completed
//   aborted       one-cycle pulse, session cancelled
//   passed        last completed session met its threshold
//   tally         result of the last completed session
// ---------------------------------------------------------------------------
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int WINDOW = 4,
    parameter int RES_W  = RES_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [RES_W-1:0] threshold,
    input  logic [NP_W-1:0]  np_in,
    input  logic [VIP_W-1:0] vip_in,
    input  logic             vvip_in,
    output logic             voter_reset,
    output logic [NP_W-1:0]  voter_np,
    output logic [VIP_W-1:0] voter_vip,
    output logic             voter_vvip,
    input  logic [RES_W-1:0] voter_result,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             passed,
    output logic [RES_W-1:0] tally
);

    // A window of zero cycles (or one longer than the counter can express)
    // is meaningless, so refuse to elaborate rather than misbehave silently.
    if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
        $error("vote_session_ctrl: WINDOW must be in 1..255");
    end

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    vote_state_e      state_q;
    vote_state_e      state_d;
    logic [CNT_W-1:0] win_cnt;
    logic [RES_W-1:0] thr_q;
    logic             win_last;
    logic             accept_start;
    logic             do_abort;
    logic             do_capture;

    assign win_last = (win_cnt == WIN_LAST);
    assign busy     = (state_q != IDLE);

    // State register. Reset drops straight back to IDLE without producing
    // either a done or an aborted pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. Everything seen by the voter is decoded
    // from the registered state only, so voter_reset and the gates cannot
    // glitch because of start/abort activity in the same cycle. The ballot
    // data itself is a plain combinational pass-through while OPEN. Abort is
    // checked ahead of the window end and the settle capture so a cancelled
    // session never reports a result.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        do_abort     = 1'b0;
        do_capture   = 1'b0;
        voter_reset  = 1'b1;
        voter_np     = '0;
        voter_vip    = '0;
        voter_vvip   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = OPEN;
                end
            end

            OPEN: begin
                voter_reset = 1'b0;
                voter_np    = np_in;
                voter_vip   = vip_in;
                voter_vvip  = vvip_in;
                if (abort) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else if (win_last) begin
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                voter_reset = 1'b0;
                if (abort) begin
                    do_abort = 1'b1;
                end else begin
                    do_capture = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Session datapath: window counter, captured threshold, result latch and
    // the done/aborted pulses. The counter restarts at zero on every accepted
    // start and only advances while the window is open, so the OPEN phase
    // always lasts exactly WINDOW cycles. tally/passed only move on a clean
    // settle, which keeps the previous result visible through aborts and
    // through the whole of the following session.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            thr_q   <= '0;
            tally   <= '0;
            passed  <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= do_capture;
            aborted <= do_abort;

            if (accept_start) begin
                thr_q   <= threshold;
                win_cnt <= '0;
            end else if (state_q == OPEN) begin
                win_cnt <= win_cnt + 1'b1;
            end

            if (do_capture) begin
                tally  <= voter_result;
                passed <= (voter_result >= thr_q);
            end
        end
    end

endmodule
